// File: rtl/frame_buf_swap_ctrl_if.sv
// Display-side bus of the ping-pong frame-buffer controller.
// Bundles the scan/render control inputs, the pixel handshake and the
// read-port signals shared by both frame buffers and the 2x1 read mux.
// master : the controller (drives sel, read port and pixel valid)
// slave  : the surrounding display/render logic
// Optional build macro: FRAME_COUNT_EN adds the 16-bit frame_cnt signal.
interface frame_buf_swap_ctrl_if #(
   parameter int ADDR_W = 15
);
   logic              scan_en;
   logic              render_done;
   logic              pix_ready;
   logic              sel;
   logic              render_buf;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              pix_valid;
   logic              frame_start;
   logic              swap_pending;
   logic              swap_done;
   logic              overrun;
`ifdef FRAME_COUNT_EN
   logic [15:0]       frame_cnt;
`endif

   modport master (
      input  scan_en,
      input  render_done,
      input  pix_ready,
      output sel,
      output render_buf,
      output rd_en,
      output rd_addr,
      output pix_valid,
      output frame_start,
      output swap_pending,
      output swap_done,
      output overrun
`ifdef FRAME_COUNT_EN
      ,
      output frame_cnt
`endif
   );

   modport slave (
      output scan_en,
      output render_done,
      output pix_ready,
      input  sel,
      input  render_buf,
      input  rd_en,
      input  rd_addr,
      input  pix_valid,
      input  frame_start,
      input  swap_pending,
      input  swap_done,
      input  overrun
`ifdef FRAME_COUNT_EN
      ,
      input  frame_cnt
`endif
   );
endinterface

// File: rtl/frame_buf_swap_ctrl.sv
// Ping-pong frame-buffer swap controller.
// Scans one buffer out through the 2x1 read mux while the renderer fills the
// other, and swaps the two only at a frame boundary. The read strobe and the
// frame_start marker are combinational on pix_ready so that a stalled pixel
// never issues a new read; every other output is registered.
// Optional build macro: FRAME_COUNT_EN adds a 16-bit boundary counter.
module frame_buf_swap_ctrl #(
   parameter int NUM_PIXELS = 19200,
   parameter int ADDR_W     = 15
) (
   input  logic                  clk,
   input  logic                  n_rst,
   frame_buf_swap_ctrl_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SCAN     = 2'd1,
      DRAIN    = 2'd2,
      BOUNDARY = 2'd3
   } state_t;

   state_t            state;
   logic              sel_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              pix_valid_q;
   logic              swap_pending_q;
   logic              swap_done_q;
   logic              overrun_q;

   logic              rd_en_c;
   logic              handshake_c;
   logic              swap_now_c;

   // Next read address, returning to zero after the last pixel of a frame.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] nxt;
      if (addr == LAST_ADDR) begin
         nxt = '0;
      end else begin
         nxt = addr + ADDR_W'(1);
      end
      return nxt;
   endfunction

   // A read is issued whenever the output register is free or being emptied.
   assign rd_en_c     = (state == SCAN) && (!pix_valid_q || bus.pix_ready);
   assign handshake_c = pix_valid_q && bus.pix_ready;
   // The swap is committed on the edge that enters BOUNDARY, so the new sel
   // and the swap_done pulse are both visible during the BOUNDARY cycle.
   assign swap_now_c  = (state == DRAIN) && handshake_c && swap_pending_q;

   // Frame scan state machine with registered mux select and status flags.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state          <= IDLE;
         sel_q          <= 1'b1;
         rd_addr_q      <= '0;
         pix_valid_q    <= 1'b0;
         swap_pending_q <= 1'b0;
         swap_done_q    <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         swap_done_q <= 1'b0;
         overrun_q   <= 1'b0;

         // A render completing in the swap cycle re-arms the pending flag
         // for the next boundary instead of counting as an overrun.
         if (swap_now_c) begin
            sel_q          <= ~sel_q;
            swap_done_q    <= 1'b1;
            swap_pending_q <= bus.render_done;
         end else if (bus.render_done) begin
            if (swap_pending_q) begin
               overrun_q <= 1'b1;
            end else begin
               swap_pending_q <= 1'b1;
            end
         end

         // The RAM output holds while rd_en is low, so pix_valid only drops
         // once the held pixel has been taken and nothing new was read.
         if (rd_en_c) begin
            pix_valid_q <= 1'b1;
         end else if (handshake_c) begin
            pix_valid_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.scan_en) begin
                  state     <= SCAN;
                  rd_addr_q <= '0;
               end
            end
            SCAN: begin
               if (rd_en_c) begin
                  rd_addr_q <= next_addr(rd_addr_q);
                  if (rd_addr_q == LAST_ADDR) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (handshake_c) begin
                  state <= BOUNDARY;
               end
            end
            BOUNDARY: begin
               // scan_en is only honoured here, so a frame always completes.
               state <= bus.scan_en ? SCAN : IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.sel          = sel_q;
   assign bus.render_buf   = sel_q;
   assign bus.rd_en        = rd_en_c;
   assign bus.rd_addr      = rd_addr_q;
   assign bus.pix_valid    = pix_valid_q;
   assign bus.frame_start  = rd_en_c && (rd_addr_q == '0);
   assign bus.swap_pending = swap_pending_q;
   assign bus.swap_done    = swap_done_q;
   assign bus.overrun      = overrun_q;

`ifdef FRAME_COUNT_EN
   logic [15:0] frame_cnt_q;

   // Count every frame boundary; the 16-bit adder wraps naturally.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         frame_cnt_q <= '0;
      end else if (state == BOUNDARY) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_frame_buf_swap_ctrl.sv
// Directed bench for frame_buf_swap_ctrl with a 4-pixel frame.
// Each scenario task starts from reset and walks a cycle-indexed timeline
// (c1 = first cycle after scan_en is sampled in IDLE) with expected values
// written out by hand.
module tb_frame_buf_swap_ctrl;

   localparam int NP = 4;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic n_rst;
   int   checks   = 0;
   int   failures = 0;

   frame_buf_swap_ctrl_if #(.ADDR_W(AW)) bus ();

   frame_buf_swap_ctrl #(
      .NUM_PIXELS(NP),
      .ADDR_W    (AW)
   ) dut (
      .clk  (clk),
      .n_rst(n_rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in IDLE with all inputs low (cycle c0 of a scenario).
   task automatic do_reset();
      n_rst           = 1'b0;
      bus.scan_en     = 1'b0;
      bus.render_done = 1'b0;
      bus.pix_ready   = 1'b0;
      nxt();
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      n_rst           = 1'b0;
      bus.scan_en     = 1'b1;
      bus.render_done = 1'b1;
      bus.pix_ready   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         nxt();
         checks++; if (bus.sel !== 1'b1) begin failures++; $display("FAIL reset_sel cyc=%0d got=%b exp=1", i, bus.sel); end
         checks++; if (bus.rd_addr !== AW'(0)) begin failures++; $display("FAIL reset_rd_addr cyc=%0d got=%0d exp=0", i, bus.rd_addr); end
         checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en cyc=%0d got=%b exp=0", i, bus.rd_en); end
         checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid cyc=%0d got=%b exp=0", i, bus.pix_valid); end
         checks++; if (bus.swap_pending !== 1'b0) begin failures++; $display("FAIL reset_swap_pending cyc=%0d got=%b exp=0", i, bus.swap_pending); end
         checks++; if (bus.swap_done !== 1'b0 || bus.overrun !== 1'b0 || bus.frame_start !== 1'b0) begin
            failures++; $display("FAIL reset_pulses cyc=%0d got swap_done=%b overrun=%b frame_start=%b exp=0", i, bus.swap_done, bus.overrun, bus.frame_start);
         end
`ifdef FRAME_COUNT_EN
         checks++; if (bus.frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", bus.frame_cnt); end
`endif
      end
      n_rst           = 1'b1;
      bus.scan_en     = 1'b0;
      bus.render_done = 1'b0;
      bus.pix_ready   = 1'b0;
   endtask

   task automatic test_clean_frame();
      int e_rd_en[7] = '{1, 1, 1, 1, 0, 0, 1};
      int e_addr [7] = '{0, 1, 2, 3, 0, 0, 0};
      int e_pv   [7] = '{0, 1, 1, 1, 1, 0, 0};
      int e_fs   [7] = '{1, 0, 0, 0, 0, 0, 1};
      do_reset();
      bus.scan_en   = 1'b1;
      bus.pix_ready = 1'b1;
      #1;
      checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL clean_idle_rd_en got=%b exp=0", bus.rd_en); end
      for (int i = 0; i < 7; i++) begin
         nxt();
         checks++; if (bus.rd_en !== e_rd_en[i][0]) begin failures++; $display("FAIL clean_rd_en c%0d got=%b exp=%0d", i + 1, bus.rd_en, e_rd_en[i]); end
         checks++; if (bus.rd_addr !== AW'(e_addr[i])) begin failures++; $display("FAIL clean_rd_addr c%0d got=%0d exp=%0d", i + 1, bus.rd_addr, e_addr[i]); end
         checks++; if (bus.pix_valid !== e_pv[i][0]) begin failures++; $display("FAIL clean_pix_valid c%0d got=%b exp=%0d", i + 1, bus.pix_valid, e_pv[i]); end
         checks++; if (bus.frame_start !== e_fs[i][0]) begin failures++; $display("FAIL clean_frame_start c%0d got=%b exp=%0d", i + 1, bus.frame_start, e_fs[i]); end
         checks++; if (bus.sel !== 1'b1 || bus.swap_done !== 1'b0) begin failures++; $display("FAIL clean_no_swap c%0d got sel=%b swap_done=%b exp sel=1 swap_done=0", i + 1, bus.sel, bus.swap_done); end
      end
`ifdef FRAME_COUNT_EN
      checks++; if (bus.frame_cnt !== 16'd1) begin failures++; $display("FAIL clean_frame_cnt got=%0d exp=1", bus.frame_cnt); end
`endif
   endtask

   task automatic test_backpressure();
      int hs = 0;
      do_reset();
      bus.scan_en   = 1'b1;
      bus.pix_ready = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         nxt();
         bus.pix_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
         if (i == 2) bus.scan_en = 1'b0;
         #1;
         if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) hs++;
         if (i >= 3 && i <= 5) begin
            checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en c%0d got=%b exp=0", i, bus.rd_en); end
            checks++; if (bus.rd_addr !== AW'(2)) begin failures++; $display("FAIL bp_rd_addr c%0d got=%0d exp=2", i, bus.rd_addr); end
            checks++; if (bus.pix_valid !== 1'b1) begin failures++; $display("FAIL bp_pix_valid c%0d got=%b exp=1", i, bus.pix_valid); end
         end
         if (i == 6) begin
            checks++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== AW'(2)) begin failures++; $display("FAIL bp_resume c6 got rd_en=%b rd_addr=%0d exp rd_en=1 rd_addr=2", bus.rd_en, bus.rd_addr); end
         end
      end
      checks++; if (hs != 4) begin failures++; $display("FAIL bp_handshakes got=%0d exp=4", hs); end
      checks++; if (bus.rd_en !== 1'b0 || bus.pix_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_after_scan_off got rd_en=%b pix_valid=%b exp=0", bus.rd_en, bus.pix_valid); end
   endtask

   task automatic test_swap();
      do_reset();
      bus.scan_en   = 1'b1;
      bus.pix_ready = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         nxt();
         bus.render_done = (i == 2);
         #1;
         if (i == 3) begin
            checks++; if (bus.swap_pending !== 1'b1) begin failures++; $display("FAIL swap_pending_set got=%b exp=1", bus.swap_pending); end
            checks++; if (bus.sel !== 1'b1) begin failures++; $display("FAIL swap_sel_hold c3 got=%b exp=1", bus.sel); end
         end
         if (i == 5) begin
            checks++; if (bus.sel !== 1'b1 || bus.swap_done !== 1'b0) begin failures++; $display("FAIL swap_drain c5 got sel=%b swap_done=%b exp sel=1 swap_done=0", bus.sel, bus.swap_done); end
         end
         if (i == 6) begin
            checks++; if (bus.sel !== 1'b0) begin failures++; $display("FAIL swap_sel_boundary got=%b exp=0", bus.sel); end
            checks++; if (bus.swap_done !== 1'b1) begin failures++; $display("FAIL swap_done_boundary got=%b exp=1", bus.swap_done); end
            checks++; if (bus.swap_pending !== 1'b0) begin failures++; $display("FAIL swap_pending_cleared got=%b exp=0", bus.swap_pending); end
         end
         if (i == 7) begin
            checks++; if (bus.swap_done !== 1'b0) begin failures++; $display("FAIL swap_done_pulse c7 got=%b exp=0", bus.swap_done); end
            checks++; if (bus.render_buf !== 1'b0 || bus.sel !== 1'b0) begin failures++; $display("FAIL swap_render_buf c7 got render_buf=%b sel=%b exp=0", bus.render_buf, bus.sel); end
         end
      end
      bus.render_done = 1'b0;
   endtask

   task automatic test_overrun();
      int ovr = 0;
      int swp = 0;
      do_reset();
      bus.scan_en   = 1'b1;
      bus.pix_ready = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         nxt();
         bus.render_done = (i == 2 || i == 3 || i == 6);
         #1;
         if (bus.overrun === 1'b1) ovr++;
         if (bus.swap_done === 1'b1) swp++;
         if (i == 3) begin
            checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_early c3 got=%b exp=0", bus.overrun); end
         end
         if (i == 4) begin
            checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse c4 got=%b exp=1", bus.overrun); end
            checks++; if (bus.swap_pending !== 1'b1) begin failures++; $display("FAIL ovr_pending_kept c4 got=%b exp=1", bus.swap_pending); end
         end
         if (i == 6) begin
            checks++; if (bus.swap_done !== 1'b1 || bus.sel !== 1'b0) begin failures++; $display("FAIL ovr_first_swap c6 got swap_done=%b sel=%b exp swap_done=1 sel=0", bus.swap_done, bus.sel); end
         end
         if (i == 7) begin
            checks++; if (bus.swap_pending !== 1'b1) begin failures++; $display("FAIL coinc_pending c7 got=%b exp=1", bus.swap_pending); end
            checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL coinc_no_overrun c7 got=%b exp=0", bus.overrun); end
            checks++; if (bus.frame_start !== 1'b1 || bus.sel !== 1'b0) begin failures++; $display("FAIL coinc_next_frame c7 got frame_start=%b sel=%b exp frame_start=1 sel=0", bus.frame_start, bus.sel); end
         end
         if (i == 11) begin
            checks++; if (bus.sel !== 1'b0) begin failures++; $display("FAIL coinc_sel_hold c11 got=%b exp=0", bus.sel); end
         end
         if (i == 12) begin
            checks++; if (bus.sel !== 1'b1 || bus.swap_done !== 1'b1) begin failures++; $display("FAIL coinc_second_swap c12 got sel=%b swap_done=%b exp sel=1 swap_done=1", bus.sel, bus.swap_done); end
            checks++; if (bus.swap_pending !== 1'b0) begin failures++; $display("FAIL coinc_pending_cleared c12 got=%b exp=0", bus.swap_pending); end
         end
      end
      checks++; if (ovr != 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ovr); end
      checks++; if (swp != 2) begin failures++; $display("FAIL swap_count got=%0d exp=2", swp); end
      bus.render_done = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      bus.scan_en   = 1'b1;
      bus.pix_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         nxt();
         bus.render_done = (i == 1);
         #1;
      end
      checks++; if (bus.rd_addr !== AW'(2) || bus.swap_pending !== 1'b1) begin failures++; $display("FAIL midrst_pre c3 got rd_addr=%0d swap_pending=%b exp rd_addr=2 swap_pending=1", bus.rd_addr, bus.swap_pending); end
      n_rst = 1'b0;
      nxt();
      bus.scan_en = 1'b0;
      n_rst       = 1'b1;
      #1;
      checks++; if (bus.sel !== 1'b1) begin failures++; $display("FAIL midrst_sel got=%b exp=1", bus.sel); end
      checks++; if (bus.swap_pending !== 1'b0) begin failures++; $display("FAIL midrst_pending got=%b exp=0", bus.swap_pending); end
      checks++; if (bus.rd_addr !== AW'(0) || bus.rd_en !== 1'b0 || bus.pix_valid !== 1'b0) begin failures++; $display("FAIL midrst_read got rd_addr=%0d rd_en=%b pix_valid=%b exp 0", bus.rd_addr, bus.rd_en, bus.pix_valid); end
      checks++; if (bus.swap_done !== 1'b0) begin failures++; $display("FAIL midrst_swap_done got=%b exp=0", bus.swap_done); end
`ifdef FRAME_COUNT_EN
      checks++; if (bus.frame_cnt !== 16'd0) begin failures++; $display("FAIL midrst_frame_cnt got=%0d exp=0", bus.frame_cnt); end
`endif
      for (int i = 0; i < 6; i++) begin
         nxt();
         checks++; if (bus.swap_done !== 1'b0 || bus.sel !== 1'b1 || bus.rd_en !== 1'b0) begin failures++; $display("FAIL midrst_quiet cyc=%0d got swap_done=%b sel=%b rd_en=%b exp 0/1/0", i, bus.swap_done, bus.sel, bus.rd_en); end
      end
   endtask

   initial begin
      n_rst           = 1'b0;
      bus.scan_en     = 1'b0;
      bus.render_done = 1'b0;
      bus.pix_ready   = 1'b0;
      test_reset();
      test_clean_frame();
      test_backpressure();
      test_swap();
      test_overrun();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule

// File: doc/frame_buf_swap_ctrl.md
Name: frame_buf_swap_ctrl

Overview:
- Ping-pong display controller directly upstream of the 32-bit 2x1 frame-buffer read mux.
- Drives the mux `sel`, so one buffer is displayed while the renderer writes the other.
- Generates scan read addresses and a valid/ready pixel handshake toward the display stage.
- Swaps buffers only at frame boundaries; a completed render is held pending until then.

Parameters:
- NUM_PIXELS, 19200, pixels per frame (160x120); minimum 2.
- ADDR_W, 15, read address width; must satisfy 2^ADDR_W >= NUM_PIXELS.

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset; synchronous, active-low; sampled on rising clk
- scan_en  input  1  level; permits frame scanning
- render_done  input  1  one-cycle pulse; renderer finished the back buffer
- pix_ready  input  1  downstream accepts the pixel this cycle
- sel  output  1  mux select; 1 routes buffer A to display, 0 routes buffer B
- render_buf  output  1  buffer the renderer may write; always equals sel (1 = B, 0 = A)
- rd_en  output  1  read strobe to both frame buffers
- rd_addr  output  ADDR_W  read address to both frame buffers
- pix_valid  output  1  mux output data is valid this cycle
- frame_start  output  1  one-cycle pulse when address 0 of a frame is issued
- swap_pending  output  1  a render_done is waiting for a frame boundary
- swap_done  output  1  one-cycle pulse in the cycle sel toggles
- overrun  output  1  one-cycle pulse; render_done arrived while swap_pending=1

Behaviour:
- Reset (n_rst=0 at clk edge), any state: go to IDLE.
  - sel=1, rd_addr=0, swap_pending=0.
  - All other outputs 0.
  - Reset mid-frame abandons the frame and drops any pending swap.
- Frame buffers are synchronous RAMs: data appears 1 cycle after rd_en and holds while rd_en=0.
- State machine:
  - IDLE: if scan_en=1, go to SCAN with rd_addr=0.
  - SCAN:
    - rd_en = !pix_valid || pix_ready.
    - Each rd_en cycle, rd_addr increments by 1 on the next edge.
    - frame_start=1 in the cycle rd_en=1 with rd_addr=0.
    - When rd_en=1 at rd_addr=NUM_PIXELS-1, go to DRAIN; rd_addr returns to 0 and does not overflow.
  - DRAIN: rd_en=0; wait until pix_valid && pix_ready, then go to BOUNDARY.
  - BOUNDARY (1 cycle):
    - If swap_pending=1: toggle sel, pulse swap_done, clear swap_pending.
    - Next state is SCAN if scan_en=1, else IDLE.
- pix_valid:
  - Registered: set on the cycle after rd_en=1.
  - Cleared after pix_valid && pix_ready when rd_en was 0 in that cycle.
  - Held while pix_ready=0, so data and pix_valid are stable under backpressure.
- scan_en deasserted mid-frame: the current frame completes. IDLE is entered only at BOUNDARY.
- render_done:
  - swap_pending=0: set swap_pending on the next edge.
  - swap_pending=1: pulse overrun next cycle; swap_pending stays 1.
  - In the BOUNDARY cycle that performs a swap: clear-then-set; pending stays 1 for the next boundary, swap_done still pulses, no overrun.
- sel changes only in BOUNDARY, so it never changes while pix_valid=1.
- Latency: first frame_start is 1 cycle after scan_en is sampled high in IDLE. First pix_valid follows 1 cycle later.

Optional Feature:
- Macro: FRAME_COUNT_EN.
- Defined: adds output frame_cnt (16 bits).
  - Reset to 0.
  - Increments by 1 in every BOUNDARY cycle; wraps 0xFFFF -> 0x0000.
- Not defined: no frame_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset check: hold n_rst=0 for 2 clk with scan_en=1 and render_done=1.
  - Required: sel=1, rd_addr=0, rd_en=0, pix_valid=0, swap_pending=0 throughout.
- Clean frame: NUM_PIXELS=4, scan_en=1, pix_ready=1.
  - rd_addr 0,1,2,3 with rd_en on 4 consecutive cycles; frame_start with address 0.
  - pix_valid high for 4 consecutive cycles, 1 cycle after rd_en.
  - Next frame_start 2 cycles after the last pixel handshake.
- Backpressure: pix_ready=0 for 3 cycles after the 2nd pixel.
  - rd_en=0 and rd_addr held at 2; pix_valid stays 1.
  - Frame still delivers exactly 4 handshakes.
- Swap at boundary: render_done pulsed mid-frame.
  - swap_pending=1 next cycle; sel stays 1 until BOUNDARY.
  - sel=0 and swap_done=1 in BOUNDARY; render_buf=0 afterward.
- Overrun and coincident swap:
  - Two render_done pulses in one frame: overrun pulses once; exactly one swap occurs.
  - render_done during BOUNDARY: swap_done=1, swap_pending stays 1, sel toggles again at the next boundary.
- Mid-frame reset: assert n_rst=0 at rd_addr=2 with swap_pending=1.
  - Return to reset values; sel=1, pending cleared, no swap_done.
  - With FRAME_COUNT_EN defined: frame_cnt=0.
